// File: rtl/ysyx_22040759_idu_pkg.sv
// Shared definitions for the registered instruction-decode stage.
// Holds:
//   - ALU/BLU operation codes (5 bits, ALU_ADD = 0)
//   - operand/PC/writeback select codes and immediate-format selectors
//   - RV32I/RV64I opcode constants
//   - dec_ctrl_t, the packed decoded control entry carried through the stage
//   - helpers: immediate extraction (32-bit, sign-extended later) and funct3 -> ALU op mapping
package ysyx_22040759_idu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_ADDW  = 5'd10;
  localparam logic [4:0] ALU_SUBW  = 5'd11;
  localparam logic [4:0] ALU_SLLW  = 5'd12;
  localparam logic [4:0] ALU_SRLW  = 5'd13;
  localparam logic [4:0] ALU_SRAW  = 5'd14;
  localparam logic [4:0] ALU_MUL   = 5'd15;
  localparam logic [4:0] ALU_MULH  = 5'd16;
  localparam logic [4:0] ALU_MULHU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_REM   = 5'd20;
  localparam logic [4:0] ALU_REMU  = 5'd21;
  localparam logic [4:0] ALU_MULW  = 5'd22;
  localparam logic [4:0] ALU_DIVW  = 5'd23;
  localparam logic [4:0] ALU_DIVUW = 5'd24;
  localparam logic [4:0] ALU_REMW  = 5'd25;
  localparam logic [4:0] ALU_REMUW = 5'd26;
  localparam logic [4:0] BLU_BEQ   = 5'd27;
  localparam logic [4:0] BLU_BNE   = 5'd28;
  localparam logic [4:0] BLU_BLT   = 5'd29;
  localparam logic [4:0] BLU_BGE   = 5'd30;

  localparam logic [1:0] A_SEL_ZERO = 2'd0;
  localparam logic [1:0] A_SEL_REG  = 2'd1;
  localparam logic [1:0] A_SEL_PC   = 2'd2;

  localparam logic [1:0] B_SEL_REG = 2'd0;
  localparam logic [1:0] B_SEL_IMM = 2'd1;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_ALU = 2'd1;
  localparam logic [1:0] PC_SEL_BLU = 2'd2;

  localparam logic [1:0] WREG_SEL_ALU = 2'd0;
  localparam logic [1:0] WREG_SEL_PC  = 2'd1;
  localparam logic [1:0] WREG_SEL_RAM = 2'd2;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] func3;
    logic [4:0] alu_sel;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] pc_sel;
    logic [1:0] wreg_sel;
    logic       reg_wen;
    logic       mem_wen;
    logic       mem_ren;
    logic       illegal;
    logic       ebreak;
  } dec_ctrl_t;

  // 32-bit sign-extended immediate; the decoder widens it to XLEN.
  function automatic logic [31:0] imm_ext32(input logic [31:0] inst, input logic [2:0] sel);
    logic [31:0] imm;
    imm = '0;
    case (sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Shared OP / OP-IMM funct3 mapping; alt selects SUB/SRA.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_22040759_idu_pipe_if.sv
// Handshake bundle between IFU, the decode stage and EXU.
//   in_*  : IFU -> stage instruction offer (valid/ready), plus flush
//   out_* : stage -> EXU decoded entry (valid/ready)
// Modports: master = IFU/EXU side (drives in_*, flush, out_ready),
//           slave  = decode stage.
interface ysyx_22040759_idu_pipe_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_func3;
  logic [4:0]      out_alu_sel;
  logic [1:0]      out_alu_a_sel;
  logic [1:0]      out_alu_b_sel;
  logic [1:0]      out_pc_sel;
  logic [1:0]      out_wreg_sel;
  logic            out_reg_wen;
  logic            out_mem_wen;
  logic            out_mem_ren;
  logic            out_illegal;
  logic            out_ebreak;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_func3,
    input  out_alu_sel, out_alu_a_sel, out_alu_b_sel, out_pc_sel, out_wreg_sel,
    input  out_reg_wen, out_mem_wen, out_mem_ren, out_illegal, out_ebreak
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_func3,
    output out_alu_sel, out_alu_a_sel, out_alu_b_sel, out_pc_sel, out_wreg_sel,
    output out_reg_wen, out_mem_wen, out_mem_ren, out_illegal, out_ebreak
  );
endinterface

// File: rtl/ysyx_22040759_idu_dec.sv
// Purely combinational RV32I/RV64I instruction decoder.
//   inst_i : instruction word
//   ctrl_o : decoded control entry (register fields, ALU/select codes, enables, flags)
//   imm_o  : selected immediate sign-extended to XLEN (zero for illegal encodings)
// Optional macro YSYX_22040759_MEXT_EN enables M-extension decode; without it every
// funct7 = 0000001 OP/OP-32 encoding is illegal.
module ysyx_22040759_idu_dec
  import ysyx_22040759_idu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst_i,
  output dec_ctrl_t       ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  localparam bit Rv64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  logic [2:0] imm_sel;
  logic       legal;
  logic       shamt_ok;
  dec_ctrl_t  c;

  always_comb begin
    opcode   = inst_i[6:0];
    funct7   = inst_i[31:25];
    f3       = inst_i[14:12];
    // inst[25] is shamt[5]: only meaningful on RV64
    shamt_ok = Rv64 || !inst_i[25];
    c        = '0;
    c.rs1    = inst_i[19:15];
    c.rs2    = inst_i[24:20];
    c.rd     = inst_i[11:7];
    c.func3  = f3;
    legal    = 1'b0;
    imm_sel  = IMM_R;

    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; imm_sel = IMM_U; c.a_sel = A_SEL_ZERO; c.b_sel = B_SEL_IMM;
        c.reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm_sel = IMM_U; c.a_sel = A_SEL_PC; c.b_sel = B_SEL_IMM;
        c.reg_wen = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; imm_sel = IMM_J; c.a_sel = A_SEL_PC; c.b_sel = B_SEL_IMM;
        c.pc_sel = PC_SEL_ALU; c.wreg_sel = WREG_SEL_PC; c.reg_wen = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); imm_sel = IMM_I; c.a_sel = A_SEL_REG; c.b_sel = B_SEL_IMM;
        c.pc_sel = PC_SEL_ALU; c.wreg_sel = WREG_SEL_PC; c.reg_wen = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1; imm_sel = IMM_B; c.a_sel = A_SEL_REG; c.b_sel = B_SEL_REG;
        c.pc_sel = PC_SEL_BLU;
        case (f3)
          3'b000:  c.alu_sel = BLU_BEQ;
          3'b001:  c.alu_sel = BLU_BNE;
          3'b100:  c.alu_sel = BLU_BLT;
          3'b101:  c.alu_sel = BLU_BGE;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        imm_sel = IMM_I; c.a_sel = A_SEL_REG; c.b_sel = B_SEL_IMM; c.mem_ren = 1'b1;
        c.wreg_sel = WREG_SEL_RAM; c.reg_wen = 1'b1;
        legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                (Rv64 && (f3 inside {3'b011, 3'b110}));
      end
      OPC_STORE: begin
        imm_sel = IMM_S; c.a_sel = A_SEL_REG; c.b_sel = B_SEL_IMM; c.mem_wen = 1'b1;
        legal = (f3 inside {3'b000, 3'b001, 3'b010}) || (Rv64 && (f3 == 3'b011));
      end
      OPC_OP_IMM: begin
        imm_sel = IMM_I; c.a_sel = A_SEL_REG; c.b_sel = B_SEL_IMM; c.reg_wen = 1'b1;
        c.alu_sel = alu_from_f3(f3, (f3 == 3'b101) && inst_i[30]);
        case (f3)
          3'b001:  legal = (inst_i[31:26] == 6'b000000) && shamt_ok;
          3'b101:  legal = ({inst_i[31], inst_i[29:26]} == 5'b00000) && shamt_ok;
          default: legal = 1'b1;
        endcase
      end
      OPC_OP_IMM_32: begin
        imm_sel = IMM_I; c.a_sel = A_SEL_REG; c.b_sel = B_SEL_IMM; c.reg_wen = 1'b1;
        case (f3)
          3'b000: begin legal = Rv64; c.alu_sel = ALU_ADDW; end
          3'b001: begin legal = Rv64 && (funct7 == 7'b0000000); c.alu_sel = ALU_SLLW; end
          3'b101: begin
            legal     = Rv64 && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
            c.alu_sel = inst_i[30] ? ALU_SRAW : ALU_SRLW;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        c.a_sel = A_SEL_REG; c.b_sel = B_SEL_REG; c.reg_wen = 1'b1;
        case (funct7)
          7'b0000000: begin legal = 1'b1; c.alu_sel = alu_from_f3(f3, 1'b0); end
          7'b0100000: begin
            legal = (f3 == 3'b000) || (f3 == 3'b101); c.alu_sel = alu_from_f3(f3, 1'b1);
          end
`ifdef YSYX_22040759_MEXT_EN
          7'b0000001: begin
            legal = 1'b1;
            case (f3)
              3'b000:  c.alu_sel = ALU_MUL;
              3'b001:  c.alu_sel = ALU_MULH;
              3'b011:  c.alu_sel = ALU_MULHU;
              3'b100:  c.alu_sel = ALU_DIV;
              3'b101:  c.alu_sel = ALU_DIVU;
              3'b110:  c.alu_sel = ALU_REM;
              3'b111:  c.alu_sel = ALU_REMU;
              default: legal = 1'b0;
            endcase
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        c.a_sel = A_SEL_REG; c.b_sel = B_SEL_REG; c.reg_wen = 1'b1;
        case ({funct7, f3})
          {7'b0000000, 3'b000}: begin legal = Rv64; c.alu_sel = ALU_ADDW; end
          {7'b0000000, 3'b001}: begin legal = Rv64; c.alu_sel = ALU_SLLW; end
          {7'b0000000, 3'b101}: begin legal = Rv64; c.alu_sel = ALU_SRLW; end
          {7'b0100000, 3'b000}: begin legal = Rv64; c.alu_sel = ALU_SUBW; end
          {7'b0100000, 3'b101}: begin legal = Rv64; c.alu_sel = ALU_SRAW; end
`ifdef YSYX_22040759_MEXT_EN
          {7'b0000001, 3'b000}: begin legal = Rv64; c.alu_sel = ALU_MULW; end
          {7'b0000001, 3'b100}: begin legal = Rv64; c.alu_sel = ALU_DIVW; end
          {7'b0000001, 3'b101}: begin legal = Rv64; c.alu_sel = ALU_DIVUW; end
          {7'b0000001, 3'b110}: begin legal = Rv64; c.alu_sel = ALU_REMW; end
          {7'b0000001, 3'b111}: begin legal = Rv64; c.alu_sel = ALU_REMUW; end
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        legal    = (inst_i == INST_EBREAK);
        c.ebreak = legal;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      c.alu_sel  = '0;
      c.a_sel    = '0;
      c.b_sel    = '0;
      c.pc_sel   = '0;
      c.wreg_sel = '0;
      c.reg_wen  = 1'b0;
      c.mem_wen  = 1'b0;
      c.mem_ren  = 1'b0;
      c.illegal  = 1'b1;
    end
    if (c.rd == 5'd0) c.reg_wen = 1'b0;

    ctrl_o = c;
    imm_o  = legal ? XLEN'($signed(imm_ext32(inst_i, imm_sel))) : '0;
  end

endmodule

// File: rtl/ysyx_22040759_idu_pipe.sv
// Registered, handshaked decode stage with a 2-entry (main + skid) buffer.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of ysyx_22040759_idu_pipe_if (in_* offer, flush, out_* entry)
//   dec_cnt  : number of entries transferred out (wraps)
// Outputs come only from the main entry; in_ready = !skid_valid so a full skid is the only
// back-pressure source. flush invalidates both entries and drops the offered input.
// Macro YSYX_22040759_MEXT_EN (see decoder) enables M-extension decode.
module ysyx_22040759_idu_pipe
  import ysyx_22040759_idu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22040759_idu_pipe_if.slave      bus,
  output logic [CNT_W-1:0]             dec_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_ctrl_t       ctrl;
  } entry_t;

  entry_t          dec_entry;
  dec_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  entry_t          main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_fire, out_fire;

  ysyx_22040759_idu_dec #(
    .XLEN (XLEN)
  ) u_dec (
    .inst_i (bus.in_inst),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm)
  );

  always_comb begin
    dec_entry    = '{pc: bus.in_pc, imm: dec_imm, ctrl: dec_ctrl};
    in_fire      = bus.in_valid && !skid_valid_q;
    out_fire     = main_valid_q && bus.out_ready;
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (bus.flush) begin
      // Payload is left as-is; only validity is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) cnt_d = cnt_q + 1'b1;
      if (out_fire || !main_valid_q) begin
        // Main is free this cycle; skid (older) wins over a new input. in_fire cannot
        // coincide with a valid skid since in_ready is low then.
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_d       = dec_entry;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready      = !skid_valid_q;
  assign bus.out_valid     = main_valid_q;
  assign bus.out_pc        = main_q.pc;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_rs1       = main_q.ctrl.rs1;
  assign bus.out_rs2       = main_q.ctrl.rs2;
  assign bus.out_rd        = main_q.ctrl.rd;
  assign bus.out_func3     = main_q.ctrl.func3;
  assign bus.out_alu_sel   = main_q.ctrl.alu_sel;
  assign bus.out_alu_a_sel = main_q.ctrl.a_sel;
  assign bus.out_alu_b_sel = main_q.ctrl.b_sel;
  assign bus.out_pc_sel    = main_q.ctrl.pc_sel;
  assign bus.out_wreg_sel  = main_q.ctrl.wreg_sel;
  assign bus.out_reg_wen   = main_q.ctrl.reg_wen;
  assign bus.out_mem_wen   = main_q.ctrl.mem_wen;
  assign bus.out_mem_ren   = main_q.ctrl.mem_ren;
  assign bus.out_illegal   = main_q.ctrl.illegal;
  assign bus.out_ebreak    = main_q.ctrl.ebreak;
  assign dec_cnt           = cnt_q;

endmodule

// File: tb/tb_ysyx_22040759_idu_pipe.sv
module tb_ysyx_22040759_idu_pipe;
  import ysyx_22040759_idu_pkg::*;

  localparam logic [31:0] I_ADDI  = 32'hFFF1_0093; // addi x1,x2,-1
  localparam logic [31:0] I_LUI   = 32'h1234_52B7; // lui x5,0x12345
  localparam logic [31:0] I_ADDI0 = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] I_SW    = 32'hFE20_AE23; // sw x2,-4(x1)
  localparam logic [31:0] I_BEQ   = 32'hFE20_8CE3; // beq x1,x2,-8
  localparam logic [31:0] I_ADDW  = 32'h0020_81BB; // addw x3,x1,x2
  localparam logic [31:0] I_MUL   = 32'h0220_81B3; // mul x3,x1,x2
  localparam logic [31:0] I_EBRK  = 32'h0010_0073;
  localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;
  localparam logic [31:0] I_SLLI32 = 32'h0200_9093; // slli x1,x1,32
  localparam logic [31:0] I_SLLI31 = 32'h01F0_9093; // slli x1,x1,31

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040759_idu_pipe_if #(.XLEN(64)) bus ();
  ysyx_22040759_idu_pipe_if #(.XLEN(32)) bus32 ();
  logic [31:0] dec_cnt;
  logic [31:0] dec_cnt32;

  ysyx_22040759_idu_pipe #(.XLEN(64), .CNT_W(32)) u_dut (
    .clk (clk), .rst (rst), .bus (bus), .dec_cnt (dec_cnt)
  );
  ysyx_22040759_idu_pipe #(.XLEN(32), .CNT_W(32)) u_dut32 (
    .clk (clk), .rst (rst), .bus (bus32), .dec_cnt (dec_cnt32)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one cycle on the 64-bit instance.
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] inst, input logic [31:0] pc);
    bus32.in_valid = 1'b1; bus32.in_inst = inst; bus32.in_pc = pc;
    tick();
    bus32.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", bus.in_ready); end
    n_cmp++; if (dec_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", dec_cnt); end
    n_cmp++; if (bus.out_imm !== 64'd0) begin n_bad++; $display("FAIL rst_imm: got %h want 0", bus.out_imm); end
    n_cmp++; if (bus.out_pc !== 64'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", bus.out_pc); end
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    issue(I_ADDI, 64'h8000_0000);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL addi_imm: got %h want all-ones", bus.out_imm); end
    n_cmp++; if (bus.out_rs1 !== 5'd2) begin n_bad++; $display("FAIL addi_rs1: got %0d want 2", bus.out_rs1); end
    n_cmp++; if (bus.out_rd !== 5'd1) begin n_bad++; $display("FAIL addi_rd: got %0d want 1", bus.out_rd); end
    n_cmp++; if (bus.out_reg_wen !== 1'b1) begin n_bad++; $display("FAIL addi_wen: got %0b want 1", bus.out_reg_wen); end
    n_cmp++; if (bus.out_alu_sel !== ALU_ADD) begin n_bad++; $display("FAIL addi_alu: got %0d want %0d", bus.out_alu_sel, ALU_ADD); end
    n_cmp++; if (bus.out_alu_b_sel !== B_SEL_IMM) begin n_bad++; $display("FAIL addi_bsel: got %0d want %0d", bus.out_alu_b_sel, B_SEL_IMM); end
    n_cmp++; if (bus.out_pc !== 64'h8000_0000) begin n_bad++; $display("FAIL addi_pc: got %h want 80000000", bus.out_pc); end
    tick(); exp_cnt++;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL hold_imm: got %h want all-ones", bus.out_imm); end

    issue(I_LUI, 64'h8000_0004);
    n_cmp++; if (bus.out_imm !== 64'h0000_0000_1234_5000) begin n_bad++; $display("FAIL lui_imm: got %h want 12345000", bus.out_imm); end
    n_cmp++; if (bus.out_alu_a_sel !== A_SEL_ZERO) begin n_bad++; $display("FAIL lui_asel: got %0d want %0d", bus.out_alu_a_sel, A_SEL_ZERO); end
    n_cmp++; if (bus.out_rd !== 5'd5) begin n_bad++; $display("FAIL lui_rd: got %0d want 5", bus.out_rd); end
    issue(I_ADDI0, 64'h8000_0008); exp_cnt++;
    n_cmp++; if (bus.out_reg_wen !== 1'b0) begin n_bad++; $display("FAIL x0_wen: got %0b want 0", bus.out_reg_wen); end
    n_cmp++; if (bus.out_illegal !== 1'b0) begin n_bad++; $display("FAIL x0_ill: got %0b want 0", bus.out_illegal); end
    issue(I_SW, 64'h8000_000C); exp_cnt++;
    n_cmp++; if (bus.out_mem_wen !== 1'b1) begin n_bad++; $display("FAIL sw_mwen: got %0b want 1", bus.out_mem_wen); end
    n_cmp++; if (bus.out_reg_wen !== 1'b0) begin n_bad++; $display("FAIL sw_wen: got %0b want 0", bus.out_reg_wen); end
    n_cmp++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL sw_imm: got %h want -4", bus.out_imm); end
    issue(I_BEQ, 64'h8000_0010); exp_cnt++;
    n_cmp++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_bad++; $display("FAIL beq_imm: got %h want -8", bus.out_imm); end
    n_cmp++; if (bus.out_pc_sel !== PC_SEL_BLU) begin n_bad++; $display("FAIL beq_pcsel: got %0d want %0d", bus.out_pc_sel, PC_SEL_BLU); end
    n_cmp++; if (bus.out_alu_sel !== BLU_BEQ) begin n_bad++; $display("FAIL beq_alu: got %0d want %0d", bus.out_alu_sel, BLU_BEQ); end
    issue(I_ADDW, 64'h8000_0014); exp_cnt++;
    n_cmp++; if (bus.out_alu_sel !== ALU_ADDW) begin n_bad++; $display("FAIL addw64_alu: got %0d want %0d", bus.out_alu_sel, ALU_ADDW); end
    n_cmp++; if (bus.out_illegal !== 1'b0) begin n_bad++; $display("FAIL addw64_ill: got %0b want 0", bus.out_illegal); end
    issue(I_MUL, 64'h8000_0018); exp_cnt++;
`ifdef YSYX_22040759_MEXT_EN
    n_cmp++; if (bus.out_alu_sel !== ALU_MUL) begin n_bad++; $display("FAIL mul_alu: got %0d want %0d", bus.out_alu_sel, ALU_MUL); end
    n_cmp++; if (bus.out_reg_wen !== 1'b1) begin n_bad++; $display("FAIL mul_wen: got %0b want 1", bus.out_reg_wen); end
`else
    n_cmp++; if (bus.out_illegal !== 1'b1) begin n_bad++; $display("FAIL mul_ill: got %0b want 1", bus.out_illegal); end
    n_cmp++; if (bus.out_reg_wen !== 1'b0) begin n_bad++; $display("FAIL mul_wen: got %0b want 0", bus.out_reg_wen); end
`endif
    issue(I_EBRK, 64'h8000_001C); exp_cnt++;
    n_cmp++; if (bus.out_ebreak !== 1'b1) begin n_bad++; $display("FAIL ebrk_flag: got %0b want 1", bus.out_ebreak); end
    n_cmp++; if (bus.out_illegal !== 1'b0) begin n_bad++; $display("FAIL ebrk_ill: got %0b want 0", bus.out_illegal); end
    issue(I_BAD, 64'h8000_0020); exp_cnt++;
    n_cmp++; if (bus.out_illegal !== 1'b1) begin n_bad++; $display("FAIL bad_ill: got %0b want 1", bus.out_illegal); end
    n_cmp++; if (bus.out_imm !== 64'd0) begin n_bad++; $display("FAIL bad_imm: got %h want 0", bus.out_imm); end
    n_cmp++; if (bus.out_reg_wen !== 1'b0) begin n_bad++; $display("FAIL bad_wen: got %0b want 0", bus.out_reg_wen); end
    tick(); exp_cnt++;
    n_cmp++; if (dec_cnt !== exp_cnt) begin n_bad++; $display("FAIL dec_cnt: got %0d want %0d", dec_cnt, exp_cnt); end
  endtask

  task automatic test_rv32();
    bus32.out_ready = 1'b1;
    issue32(I_ADDW, 32'h100);
    n_cmp++; if (bus32.out_illegal !== 1'b1) begin n_bad++; $display("FAIL addw32_ill: got %0b want 1", bus32.out_illegal); end
    n_cmp++; if (bus32.out_reg_wen !== 1'b0) begin n_bad++; $display("FAIL addw32_wen: got %0b want 0", bus32.out_reg_wen); end
    n_cmp++; if (bus32.out_imm !== 32'd0) begin n_bad++; $display("FAIL addw32_imm: got %h want 0", bus32.out_imm); end
    issue32(I_SLLI32, 32'h104);
    n_cmp++; if (bus32.out_illegal !== 1'b1) begin n_bad++; $display("FAIL slli32_ill: got %0b want 1", bus32.out_illegal); end
    issue32(I_SLLI31, 32'h108);
    n_cmp++; if (bus32.out_illegal !== 1'b0) begin n_bad++; $display("FAIL slli31_ill: got %0b want 0", bus32.out_illegal); end
    n_cmp++; if (bus32.out_alu_sel !== ALU_SLL) begin n_bad++; $display("FAIL slli31_alu: got %0d want %0d", bus32.out_alu_sel, ALU_SLL); end
    issue32(I_LUI, 32'h10C);
    n_cmp++; if (bus32.out_imm !== 32'h1234_5000) begin n_bad++; $display("FAIL lui32_imm: got %h want 12345000", bus32.out_imm); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.in_inst = I_ADDI; bus.in_pc = 64'h100 + 64'(4 * k);
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100 + 64'(4 * k)) begin
        n_bad++; $display("FAIL b2b_out[%0d]: got v=%0b pc=%h want v=1 pc=%h", k, bus.out_valid, bus.out_pc, 64'h100 + 64'(4 * k));
      end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %0b want 1", k, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    tick(); exp_cnt += 4;
    n_cmp++; if (dec_cnt !== exp_cnt) begin n_bad++; $display("FAIL b2b_cnt: got %0d want %0d", dec_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int k;
    int n_out;
    bus.out_ready = 1'b0;
    issue(I_ADDI, 64'h200);
    issue(I_ADDI, 64'h204);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %0b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_pc !== 64'h200) begin n_bad++; $display("FAIL bp_head: got %h want 200", bus.out_pc); end
    k = 2; n_out = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && n_out < 4; cyc++) begin
      bus.in_valid = (k < 4); bus.in_inst = I_ADDI; bus.in_pc = 64'h200 + 64'(4 * k);
      if (bus.out_valid) begin
        n_cmp++; if (bus.out_pc !== 64'h200 + 64'(4 * n_out)) begin
          n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", n_out, bus.out_pc, 64'h200 + 64'(4 * n_out));
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) k++;
      tick();
    end
    bus.in_valid = 1'b0;
    exp_cnt += 4;
    n_cmp++; if (n_out !== 4) begin n_bad++; $display("FAIL bp_count: got %0d outputs want 4", n_out); end
    n_cmp++; if (dec_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt: got %0d want %0d", dec_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    int seen;
    bus.out_ready = 1'b0;
    issue(I_ADDI, 64'h300);
    issue(I_ADDI, 64'h304);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_full: got %0b want 0", bus.in_ready); end
    // Out transfer in the flush cycle must not be counted.
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    issue(I_ADDI, 64'h308);
    bus.flush = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_ready: got %0b want 1", bus.in_ready); end
    n_cmp++; if (dec_cnt !== exp_cnt) begin n_bad++; $display("FAIL fl_cnt: got %0d want %0d", dec_cnt, exp_cnt); end
    // Flush with only main full: input offered with in_ready = 1 is still dropped.
    bus.out_ready = 1'b0;
    issue(I_ADDI, 64'h310);
    bus.flush = 1'b1;
    issue(I_ADDI, 64'h314);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL fl_drop: got %0d outputs want 0", seen); end
    n_cmp++; if (dec_cnt !== exp_cnt) begin n_bad++; $display("FAIL fl_cnt2: got %0d want %0d", dec_cnt, exp_cnt); end
  endtask

  task automatic test_rst_mid();
    bus.out_ready = 1'b0;
    issue(I_ADDI, 64'h400);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre: got %0b want 1", bus.out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_pc !== 64'd0 || bus.out_imm !== 64'd0) begin
      n_bad++; $display("FAIL rm_payload: got pc=%h imm=%h want 0", bus.out_pc, bus.out_imm);
    end
    n_cmp++; if (dec_cnt !== 32'd0) begin n_bad++; $display("FAIL rm_cnt: got %0d want 0", dec_cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %0b want 1", bus.in_ready); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.in_pc = '0; bus32.flush = 1'b0;
    bus32.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_decode();
    test_rv32();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
